eth_frame_tx: RTL

- Parametrised Ethernet TX frame builder; successor to the fixed-size ARP/UDP sender.
- Emits ARP request/response frames and UDP/IPv4 datagrams of runtime-selectable length as a 32-bit valid/ready word stream toward the MAC.
- Fragments UDP datagrams with a correct MF flag and offsets, a per-datagram IP ID, and a full IP header checksum.
- Payload is read from a word-addressed buffer; sits between the acquisition buffer and the MAC TX FIFO.

---
 rtl/eth_pkg.sv | 33 +++
 rtl/eth_frame_tx_ip_csum.sv | 18 +
 rtl/eth_frame_tx.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet TX frame builder (ARP + fragmented UDP/IPv4).
package eth_pkg;
  localparam logic [3:0]  PKT_ARP_REQ  = 4'd1;
  localparam logic [3:0]  PKT_ARP_RESP = 4'd2;
  localparam logic [3:0]  PKT_UDP      = 4'd3;

  localparam logic [15:0] ETH_IPV4     = 16'h0800;
  localparam logic [15:0] ETH_ARP      = 16'h0806;

  localparam logic [15:0] ARP_HTYPE    = 16'h0001;
  localparam logic [15:0] ARP_PTYPE    = 16'h0800;
  localparam logic [7:0]  ARP_HLEN     = 8'd6;
  localparam logic [7:0]  ARP_PLEN     = 8'd4;

  localparam logic [3:0]  IP_VER       = 4'd4;
  localparam logic [3:0]  IP_IHL       = 4'd5;
  localparam logic [7:0]  IP_PROTO_UDP = 8'd17;

  localparam logic [3:0]  HDR_ARP_W       = 4'd11;
  localparam logic [3:0]  HDR_UDP_FIRST_W = 4'd11;
  localparam logic [3:0]  HDR_UDP_NEXT_W  = 4'd9;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_HDR, S_PAY, S_GAP, S_DONE} state_e;

  typedef struct packed {
    logic [3:0]  pkt_type;
    logic [15:0] udp_len;
    logic [47:0] self_mac;
    logic [47:0] target_mac;
    logic [31:0] self_ip;
    logic [31:0] target_ip;
  } req_t;
endpackage

// File: rtl/eth_frame_tx_ip_csum.sv
// IPv4 header checksum over the nine non-checksum halfwords (combinational).
module ip_csum (
  input  logic [8:0][15:0] i_hw,
  output logic [15:0]      o_csum
);
  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  // Nine 16-bit terms fit in 20 bits; two folds always absorb the carries.
  always_comb begin
    sum = '0;
    for (int i = 0; i < 9; i++) sum = sum + 20'(i_hw[i]);
    fold1  = 17'(sum[15:0]) + 17'(sum[19:16]);
    fold2  = fold1[15:0] + 16'(fold1[16]);
    o_csum = ~fold2;
  end
endmodule

// File: rtl/eth_frame_tx.sv
// Ethernet TX frame builder: ARP request/response and fragmented UDP/IPv4 as a 32-bit stream.
module eth_frame_tx #(
  parameter int ADDR_W   = 11,
  parameter int FRAG_MAX = 1400,
  parameter int SRC_PORT = 2179,
  parameter int DST_PORT = 5152,
  parameter int IP_TTL   = 200,
  parameter int IFG_CYC  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [3:0]        i_pkt_type,
  input  logic [15:0]       i_udp_len,
  input  logic [47:0]       i_self_mac,
  input  logic [47:0]       i_target_mac,
  input  logic [31:0]       i_self_ip,
  input  logic [31:0]       i_target_ip,
  output logic [31:0]       o_data,
  output logic              o_vld,
  input  logic              i_rdy,
  output logic              o_sop,
  output logic              o_eop,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [31:0]       i_rd_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);
  import eth_pkg::*;

  localparam int          MAX_LEN = 4 * (2 ** ADDR_W);
  localparam logic [16:0] FRAG_L  = 17'(FRAG_MAX);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [15:0]       id_q, id_d;
  logic [16:0]       rem_q, rem_d;
  logic [15:0]       sent_q, sent_d;
  logic              first_q, first_d;
  logic [15:0]       frag_q, frag_d;
  logic              mf_q, mf_d;
  logic [15:0]       csum_q, csum_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [15:0]       pay_q, pay_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [15:0]       gap_q, gap_d;
  logic              err_q, err_d;

  logic              is_arp, start_bad, mf_c;
  logic [16:0]       frag_c;
  logic [3:0]        hdr_last;
  logic [31:0]       hdr_word;
  logic [8:0][15:0]  csum_hw;
  logic [15:0]       csum_c;

  assign is_arp   = (req_q.pkt_type != PKT_UDP);
  assign hdr_last = is_arp  ? HDR_ARP_W - 4'd1 :
                    first_q ? HDR_UDP_FIRST_W - 4'd1 : HDR_UDP_NEXT_W - 4'd1;
  assign mf_c     = (rem_q > FRAG_L);
  assign frag_c   = mf_c ? FRAG_L : rem_q;

  // Offset comes from sent_q, which only moves on the last payload word.
  assign csum_hw[0] = {IP_VER, IP_IHL, 8'h00};
  assign csum_hw[1] = frag_c[15:0] + 16'd20;
  assign csum_hw[2] = id_q;
  assign csum_hw[3] = {2'b00, mf_c, sent_q[15:3]};
  assign csum_hw[4] = {8'(IP_TTL), IP_PROTO_UDP};
  assign csum_hw[5] = req_q.self_ip[31:16];
  assign csum_hw[6] = req_q.self_ip[15:0];
  assign csum_hw[7] = req_q.target_ip[31:16];
  assign csum_hw[8] = req_q.target_ip[15:0];

  ip_csum u_csum (.i_hw(csum_hw), .o_csum(csum_c));

  always_comb begin
    start_bad = 1'b0;
    if (!(i_pkt_type inside {PKT_ARP_REQ, PKT_ARP_RESP, PKT_UDP}))
      start_bad = 1'b1;
    else if (i_pkt_type == PKT_UDP &&
             (i_udp_len == 16'd0 || i_udp_len[1:0] != 2'b00 || 32'(i_udp_len) > MAX_LEN))
      start_bad = 1'b1;
  end

  always_comb begin
    hdr_word = '0;
    case (wcnt_q)
      4'd0:  hdr_word = {16'h0, req_q.target_mac[47:32]};
      4'd1:  hdr_word = req_q.target_mac[31:0];
      4'd2:  hdr_word = req_q.self_mac[47:16];
      4'd3:  hdr_word = {req_q.self_mac[15:0], is_arp ? ETH_ARP : ETH_IPV4};
      4'd4:  hdr_word = is_arp ? {ARP_HTYPE, ARP_PTYPE}
                               : {IP_VER, IP_IHL, 8'h00, frag_q + 16'd20};
      4'd5:  hdr_word = is_arp ? {ARP_HLEN, ARP_PLEN, 12'h0, req_q.pkt_type}
                               : {id_q, 2'b00, mf_q, sent_q[15:3]};
      4'd6:  hdr_word = is_arp ? req_q.self_mac[47:16]
                               : {8'(IP_TTL), IP_PROTO_UDP, csum_q};
      4'd7:  hdr_word = is_arp ? {req_q.self_mac[15:0], req_q.self_ip[31:16]} : req_q.self_ip;
      4'd8:  hdr_word = is_arp ? {req_q.self_ip[15:0], req_q.target_mac[47:32]} : req_q.target_ip;
      4'd9:  hdr_word = is_arp ? req_q.target_mac[31:0] : {16'(SRC_PORT), 16'(DST_PORT)};
      4'd10: hdr_word = is_arp ? req_q.target_ip : {req_q.udp_len + 16'd8, 16'h0};
      default: hdr_word = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    id_d      = id_q;
    rem_d     = rem_q;
    sent_d    = sent_q;
    first_d   = first_q;
    frag_d    = frag_q;
    mf_d      = mf_q;
    csum_d    = csum_q;
    wcnt_d    = wcnt_q;
    pay_d     = pay_q;
    rd_addr_d = rd_addr_q;
    gap_d     = gap_q;
    err_d     = 1'b0;
    unique case (state_q)
      S_IDLE: if (i_start) begin
        if (start_bad) err_d = 1'b1;
        else begin
          req_d.pkt_type   = i_pkt_type;
          req_d.udp_len    = i_udp_len;
          req_d.self_mac   = i_self_mac;
          req_d.target_mac = i_target_mac;
          req_d.self_ip    = i_self_ip;
          req_d.target_ip  = i_target_ip;
          rem_d            = 17'(i_udp_len) + 17'd8;
          sent_d           = '0;
          first_d          = 1'b1;
          rd_addr_d        = '0;
          wcnt_d           = '0;
          state_d          = (i_pkt_type == PKT_UDP) ? S_CALC : S_HDR;
        end
      end
      S_CALC: begin
        frag_d  = frag_c[15:0];
        mf_d    = mf_c;
        csum_d  = csum_c;
        pay_d   = 16'((frag_c - (first_q ? 17'd8 : 17'd0)) >> 2);
        wcnt_d  = '0;
        state_d = S_HDR;
      end
      S_HDR: if (i_rdy) begin
        if (wcnt_q == hdr_last) state_d = is_arp ? S_DONE : S_PAY;
        else                    wcnt_d  = wcnt_q + 4'd1;
      end
      S_PAY: if (i_rdy) begin
        rd_addr_d = rd_addr_q + ADDR_W'(1);
        pay_d     = pay_q - 16'd1;
        if (pay_q == 16'd1) begin
          rem_d   = rem_q - 17'(frag_q);
          sent_d  = sent_q + frag_q;
          first_d = 1'b0;
          gap_d   = '0;
          state_d = mf_q ? S_GAP : S_DONE;
        end
      end
      S_GAP: begin
        if (gap_q == 16'(IFG_CYC - 1)) state_d = S_CALC;
        else                           gap_d   = gap_q + 16'd1;
      end
      S_DONE: begin
        if (!is_arp) id_d = id_q + 16'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      id_q      <= '0;
      rem_q     <= '0;
      sent_q    <= '0;
      first_q   <= 1'b0;
      frag_q    <= '0;
      mf_q      <= 1'b0;
      csum_q    <= '0;
      wcnt_q    <= '0;
      pay_q     <= '0;
      rd_addr_q <= '0;
      gap_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      id_q      <= id_d;
      rem_q     <= rem_d;
      sent_q    <= sent_d;
      first_q   <= first_d;
      frag_q    <= frag_d;
      mf_q      <= mf_d;
      csum_q    <= csum_d;
      wcnt_q    <= wcnt_d;
      pay_q     <= pay_d;
      rd_addr_q <= rd_addr_d;
      gap_q     <= gap_d;
      err_q     <= err_d;
    end
  end

  assign o_vld     = (state_q == S_HDR) || (state_q == S_PAY);
  assign o_data    = (state_q == S_PAY) ? i_rd_data : (state_q == S_HDR) ? hdr_word : '0;
  assign o_sop     = (state_q == S_HDR) && (wcnt_q == 4'd0);
  assign o_eop     = is_arp ? ((state_q == S_HDR) && (wcnt_q == hdr_last))
                            : ((state_q == S_PAY) && (pay_q == 16'd1));
  assign o_rd_addr = rd_addr_q;
  assign o_busy    = state_q inside {S_CALC, S_HDR, S_PAY, S_GAP};
  assign o_done    = (state_q == S_DONE);
  assign o_err     = err_q;
endmodule
